qrd_row_skewer: RTL and testbench

Parametrised input front-end for the QRD systolic array. Accepts one augmented column of [H | y] per beat (N complex elements, all rows in parallel) over a valid/ready handshake. Produces the row-skewed stream the array consumes: row r is delayed r cycles relative to row 0. It also marks each row's first column and optionally checks matrix framing. It generalises the fixed 4x4, 14-bit skew to N rows and W-bit data, adds downstream backpressure and per-lane valids, and supports back-to-back matrices.

---
 rtl/qrd_row_skewer.sv | 102 ++++++++++
 tb/tb_qrd_row_skewer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qrd_row_skewer.sv
// qrd_row_skewer: row-skewing input front-end for the QRD systolic array.
// Define QRD_SKEW_FRAMECHK_EN to enable in_last framing check (frame_err).
module qrd_row_skewer #(
    parameter int N = 4,
    parameter int W = 14
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_last,
    input  logic [N*W-1:0] in_col_r,
    input  logic [N*W-1:0] in_col_i,
    input  logic           dn_ready,
    output logic [N*W-1:0] row_out_r,
    output logic [N*W-1:0] row_out_i,
    output logic [N-1:0]   row_out_v,
    output logic [N-1:0]   row_out_f,
    output logic           busy,
    output logic           frame_err
);

    localparam int CW = $clog2(N + 1);
    localparam int E  = 2 * W + 2;
    localparam logic [CW-1:0] LAST_COL = CW'(N);

    logic [CW-1:0] col_cnt;
    logic          accept;
    logic          col_is_last;
    logic          first;
    logic [N-1:0]  lane_busy;

    assign in_ready    = dn_ready;
    assign accept      = in_valid & dn_ready;
    assign col_is_last = (col_cnt == LAST_COL);
    assign first       = in_valid & (col_cnt == '0);
    assign busy        = |lane_busy;

`ifdef QRD_SKEW_FRAMECHK_EN
    // in_last resyncs the column counter to the producer's framing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (in_last != col_is_last)
                frame_err <= 1'b1;
            if (in_last || col_is_last)
                col_cnt <= '0;
            else
                col_cnt <= col_cnt + 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign frame_err      = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            col_cnt <= '0;
        else if (accept)
            col_cnt <= col_is_last ? '0 : col_cnt + 1'b1;
    end
`endif

    // Each lane packs its stages as {f, v, im, re}; stage r is the output
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [(r+1)*E-1:0] sh;
        logic [(r+1)*E-1:0] shifted;
        logic [E-1:0]       nxt;
        logic [r:0]         vbits;

        assign nxt = in_valid
            ? {first, 1'b1, in_col_i[r*W +: W], in_col_r[r*W +: W]}
            : '0;

        if (r == 0) begin : g_one
            assign shifted = nxt;
        end else begin : g_many
            assign shifted = {sh[r*E-1:0], nxt};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                sh <= '0;
            else if (dn_ready)
                sh <= shifted;
        end

        for (genvar k = 0; k <= r; k++) begin : g_v
            assign vbits[k] = sh[k*E + 2*W];
        end

        assign lane_busy[r]       = |vbits;
        assign row_out_r[r*W +: W] = sh[r*E +: W];
        assign row_out_i[r*W +: W] = sh[r*E + W +: W];
        assign row_out_v[r]       = sh[r*E + 2*W];
        assign row_out_f[r]       = sh[r*E + 2*W + 1];
    end

endmodule

// File: tb/tb_qrd_row_skewer.sv
// tb_qrd_row_skewer: scoreboard bench with a column-window reference model.
// Honours QRD_SKEW_FRAMECHK_EN for the framing-error scenario.
module tb_qrd_row_skewer;

    localparam int N = 4;
    localparam int W = 14;

    typedef struct packed {
        logic           f;
        logic           v;
        logic [N*W-1:0] im;
        logic [N*W-1:0] re;
    } col_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_last = 1'b0;
    logic [N*W-1:0] in_col_r = '0;
    logic [N*W-1:0] in_col_i = '0;
    logic           dn_ready = 1'b1;
    logic [N*W-1:0] row_out_r;
    logic [N*W-1:0] row_out_i;
    logic [N-1:0]   row_out_v;
    logic [N-1:0]   row_out_f;
    logic           busy;
    logic           frame_err;

    int   checks = 0;
    int   errors = 0;
    col_t win[$];
    int   col;
    logic exp_ferr;

    always #5 clk = ~clk;

    qrd_row_skewer #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_col_r(in_col_r), .in_col_i(in_col_i), .dn_ready(dn_ready),
        .row_out_r(row_out_r), .row_out_i(row_out_i),
        .row_out_v(row_out_v), .row_out_f(row_out_f),
        .busy(busy), .frame_err(frame_err)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Window of the last N columns pushed into the array, oldest first
    function automatic void model_reset();
        win.delete();
        for (int i = 0; i < N; i++) win.push_back('0);
        col      = 0;
        exp_ferr = 1'b0;
    endfunction

    // Stimulus side: every advance pushes one column (or bubble)
    always @(posedge clk) begin
        col_t b;
        b = '0;
        if (rst_n && dn_ready) begin
            if (in_valid) begin
                b.v  = 1'b1;
                b.f  = (col == 0);
                b.re = in_col_r;
                b.im = in_col_i;
`ifdef QRD_SKEW_FRAMECHK_EN
                if (in_last != (col == N)) exp_ferr = 1'b1;
                col = in_last ? 0 : ((col == N) ? 0 : col + 1);
`else
                col = (col == N) ? 0 : col + 1;
`endif
            end
            win.push_back(b);
            void'(win.pop_front());
        end
    end

    // Monitor: lane r must present the column pushed r advances ago
    always @(negedge clk) begin
        col_t e;
        logic eb;
        eb = 1'b0;
        for (int r = 0; r < N; r++) begin
            e = win[N-1-r];
            eb |= e.v;
            chk($sformatf("lane%0d", r),
                64'({row_out_f[r], row_out_v[r],
                     row_out_i[r*W +: W], row_out_r[r*W +: W]}),
                64'({e.f, e.v, e.im[r*W +: W], e.re[r*W +: W]}));
        end
        chk("busy", 64'(busy), 64'(eb));
        chk("in_ready", 64'(in_ready), 64'(dn_ready));
        chk("frame_err", 64'(frame_err), 64'(exp_ferr));
    end

    function automatic logic [N*W-1:0] rnd_col();
        logic [N*W-1:0] c;
        for (int r = 0; r < N; r++) c[r*W +: W] = W'($urandom);
        return c;
    endfunction

    task automatic drive(input logic v, input logic dn, input int last);
        in_valid = v;
        in_col_r = rnd_col();
        in_col_i = rnd_col();
        dn_ready = dn;
        in_last  = (last < 0) ? (col == N) : (last != 0);
        @(posedge clk);
        #2;
    endtask

    task automatic matrix();
        for (int c = 0; c <= N; c++) drive(1'b1, 1'b1, -1);
    endtask

    task automatic drain();
        for (int i = 0; i <= N; i++) drive(1'b0, 1'b1, -1);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_v", 64'(row_out_v), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Single matrix with known y elements on rows 0 and 3
        for (int c = 0; c <= N; c++) begin
            in_valid = 1'b1;
            dn_ready = 1'b1;
            in_last  = (c == N);
            in_col_r = rnd_col();
            in_col_i = rnd_col();
            if (c == N) begin
                in_col_r[0 +: W]   = W'(181);
                in_col_i[0 +: W]   = W'(724);
                in_col_r[3*W +: W] = W'(724);
                in_col_i[3*W +: W] = W'(181);
            end
            @(posedge clk);
            #2;
        end
        chk("y_lane0", 64'({row_out_r[0 +: W], row_out_i[0 +: W]}),
            64'({W'(181), W'(724)}));
        repeat (3) drive(1'b0, 1'b1, -1);
        chk("y_lane3", 64'({row_out_r[3*W +: W], row_out_i[3*W +: W]}),
            64'({W'(724), W'(181)}));
        chk("busy_hi", 64'(busy), 64'(1));
        drive(1'b0, 1'b1, -1);
        chk("busy_lo", 64'(busy), 64'(0));

        // Backpressure for 3 cycles mid-matrix
        drive(1'b1, 1'b1, -1);
        drive(1'b1, 1'b1, -1);
        repeat (3) drive(1'b1, 1'b0, -1);
        repeat (3) drive(1'b1, 1'b1, -1);
        drain();

        // Bubble between columns 1 and 2
        drive(1'b1, 1'b1, -1);
        drive(1'b1, 1'b1, -1);
        drive(1'b0, 1'b1, -1);
        repeat (3) drive(1'b1, 1'b1, -1);
        drain();

        // Back-to-back matrices
        matrix();
        matrix();
        drain();

        // Reset mid-stream
        repeat (3) drive(1'b1, 1'b1, -1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(row_out_v), 64'(0));
        chk("mid_rst_r", 64'(row_out_r), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        matrix();
        drain();

`ifdef QRD_SKEW_FRAMECHK_EN
        // Premature in_last on column 3
        for (int c = 0; c < N; c++) drive(1'b1, 1'b1, (c == N - 1) ? 1 : 0);
        chk("ferr_set", 64'(frame_err), 64'(1));
        matrix();
        drain();
        chk("ferr_sticky", 64'(frame_err), 64'(1));
`endif

        // Randomised traffic with bubbles and backpressure
        for (int i = 0; i < 400; i++)
            drive(($urandom % 10) < 7, ($urandom % 10) < 8, -1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
